// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg: shared types for the mac_seq streaming multiply-accumulate block.
//   mode_t     - operation selected with operand a
//   state_t    - operand-collection FSM states
//   pipe_rec_t - per-stage control record carried alongside the result data
package mac_seq_pkg;

    typedef enum logic [1:0] {
        MODE_MAD = 2'b00,   // a*b + c
        MODE_MSB = 2'b01,   // a*b - c
        MODE_RSB = 2'b10,   // c - a*b
        MODE_MUL = 2'b11    // a*b, c consumed and ignored
    } mode_t;

    typedef enum logic [1:0] {
        S_A = 2'd0,
        S_B = 2'd1,
        S_C = 2'd2
    } state_t;

    // Data width is a module parameter, so the W-bit result travels in a
    // separate array; this record holds the width-independent part.
    typedef struct packed {
        logic vld;
        logic ovf;
    } pipe_rec_t;

endpackage

// File: rtl/mac_seq_if.sv
// mac_seq_if: operand stream (in_*), result stream (out_*) and abort pulse.
//   slave  - the mac_seq block
//   master - the producer/consumer driving it
interface mac_seq_if
    import mac_seq_pkg::*;
#(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    mode_t        in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_ovf;
    logic         err_abort;

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_ovf, err_abort
    );

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, err_abort
    );
endinterface

// File: rtl/mac_seq_fifo.sv
// mac_seq_fifo: synchronous FIFO, power-of-two depth, with occupancy count.
//   clk, rst   - clock, async active-high reset (empties the FIFO)
//   push, din  - write request / data (ignored when full unless popping too)
//   pop        - read request (ignored when empty)
//   dout       - head entry, forced to zero while empty
//   empty      - no entries
//   count      - number of stored entries, 0..DEPTH
module mac_seq_fifo #(
    parameter  int DW    = 33,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic [CW-1:0] count
);
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so push on full is accepted then.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    assign dout = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/mac_seq.sv
// mac_seq: collects a, b, c from one valid/ready stream and produces
// a*b+c / a*b-c / c-a*b / a*b (mode sampled with a) through a MUL_STAGES-deep
// pipeline into an output FIFO.
//   clk, rst - clock, async active-high reset
//   bus      - mac_seq_if.slave: in_* operand stream, out_* result stream
//              (out_ovf = exact result < 0 or >= 2^W), err_abort pulse
// in_ready is a credit: results in flight plus FIFO occupancy must stay below
// OFIFO_DEPTH, so the pipeline never needs to stall.
module mac_seq
    import mac_seq_pkg::*;
#(
    parameter int W           = 32,
    parameter int MUL_STAGES  = 2,
    parameter int OFIFO_DEPTH = 4
)(
    input logic      clk,
    input logic      rst,
    mac_seq_if.slave bus
);
    localparam int PRW = 2 * W;
    localparam int PW  = 2 * W + 2;
    localparam int CW  = $clog2(OFIFO_DEPTH) + 1;

    state_t       state, state_nxt;
    logic [W-1:0] a_q, b_q;
    mode_t        mode_q;
    logic         hs, launch, abort, err_q;

    assign hs = bus.in_valid && bus.in_ready;

    // A ready cycle with no operand mid-transaction drops the partial operands.
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        abort     = 1'b0;
        case (state)
            S_A: if (hs) state_nxt = S_B;
            S_B, S_C: begin
                if (hs) begin
                    state_nxt = (state == S_B) ? S_C : S_A;
                    launch    = (state == S_C);
                end else if (bus.in_ready) begin
                    state_nxt = S_A;
                    abort     = 1'b1;
                end
            end
            default: state_nxt = S_A;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_A;
            err_q  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= MODE_MAD;
        end else begin
            state <= state_nxt;
            err_q <= abort;
            if (hs && state == S_A) begin
                a_q    <= bus.in_data;
                mode_q <= bus.in_mode;
            end
            if (hs && state == S_B) b_q <= bus.in_data;
        end
    end

    // Full-precision signed result; c arrives live on in_data during the launch.
    logic [PRW-1:0]       prod;
    logic signed [PW-1:0] prod_s, c_s, res;
    logic                 res_ovf;

    always_comb begin
        prod   = PRW'(a_q) * PRW'(b_q);
        prod_s = $signed({2'b00, prod});
        c_s    = $signed({{(W + 2){1'b0}}, bus.in_data});
        res    = prod_s;
        case (mode_q)
            MODE_MAD: res = prod_s + c_s;
            MODE_MSB: res = prod_s - c_s;
            MODE_RSB: res = c_s - prod_s;
            default:  res = prod_s;
        endcase
        res_ovf = res[PW-1] | (|res[PW-2:W]);
    end

    // Result is formed at launch; the remaining stages only delay it so that
    // the FIFO write lands exactly MUL_STAGES edges after the c handshake.
    pipe_rec_t [MUL_STAGES:1]        rec_pipe;
    logic      [MUL_STAGES:1][W-1:0] dat_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rec_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            rec_pipe[1] <= '{vld: launch, ovf: res_ovf};
            dat_pipe[1] <= res[W-1:0];
            for (int s = 2; s <= MUL_STAGES; s++) begin
                rec_pipe[s] <= rec_pipe[s-1];
                dat_pipe[s] <= dat_pipe[s-1];
            end
        end
    end

    logic [CW-1:0] inflight, fifo_cnt;
    logic [W:0]    fifo_dout;
    logic          fifo_empty;

    always_comb begin
        inflight = '0;
        for (int s = 1; s <= MUL_STAGES; s++)
            inflight = inflight + CW'(rec_pipe[s].vld);
    end

    // Only registered state feeds the credit, so in_ready moves on edges only.
    assign bus.in_ready = (inflight + fifo_cnt) < CW'(OFIFO_DEPTH);

    mac_seq_fifo #(
        .DW    (W + 1),
        .DEPTH (OFIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rec_pipe[MUL_STAGES].vld),
        .din   ({rec_pipe[MUL_STAGES].ovf, dat_pipe[MUL_STAGES]}),
        .pop   (bus.out_valid && bus.out_ready),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_dout[W-1:0];
    assign bus.out_ovf   = fifo_dout[W];
    assign bus.err_abort = err_q;
endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq: directed test-plan scenarios with literal expectations, then a
// randomized stream; a transaction-level model is compared every cycle.
module tb_mac_seq;
    import mac_seq_pkg::*;

    localparam int W     = 32;
    localparam int MS    = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mac_seq_if #(.W(W)) bus();

    mac_seq #(.W(W), .MUL_STAGES(MS), .OFIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int           due;
        logic [W-1:0] d;
        logic         o;
    } res_t;

    res_t         infl[$];
    res_t         fq[$];
    int           phase  = 0;
    int           edge_n = 0;
    logic [W-1:0] ma, mb;
    mode_t        mm;
    logic         abort_m = 1'b0;

    function automatic res_t calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] c, input mode_t m, input int due);
        logic signed [127:0] p, cc, r, lim;
        res_t x;
        p   = $signed(128'(a) * 128'(b));
        cc  = $signed(128'(c));
        lim = 128'sd1 <<< W;
        case (m)
            MODE_MAD: r = p + cc;
            MODE_MSB: r = p - cc;
            MODE_RSB: r = cc - p;
            default:  r = p;
        endcase
        x.due = due;
        x.d   = r[W-1:0];
        x.o   = (r < 0) || (r >= lim);
        return x;
    endfunction

    // Checks the state reached after the previous edge, then advances the
    // model by the edge that is about to happen.
    always @(negedge clk) begin
        bit rdy, hs, pop;
        if (rst) begin
            infl.delete();
            fq.delete();
            phase   = 0;
            abort_m = 1'b0;
            chk("rst_in_ready",  bus.in_ready,  1);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_out_data",  bus.out_data,  0);
            chk("rst_out_ovf",   bus.out_ovf,   0);
            chk("rst_err_abort", bus.err_abort, 0);
        end else begin
            edge_n++;
            rdy = (infl.size() + fq.size()) < DEPTH;
            chk("m_in_ready",  bus.in_ready,  rdy);
            chk("m_out_valid", bus.out_valid, fq.size() != 0);
            chk("m_err_abort", bus.err_abort, abort_m);
            if (fq.size() != 0) begin
                chk("m_out_data", bus.out_data, fq[0].d);
                chk("m_out_ovf",  bus.out_ovf,  fq[0].o);
            end
            hs      = bus.in_valid && rdy;
            pop     = (fq.size() != 0) && bus.out_ready;
            abort_m = (phase != 0) && rdy && !bus.in_valid;
            if (pop) void'(fq.pop_front());
            while (infl.size() != 0 && infl[0].due == edge_n)
                fq.push_back(infl.pop_front());
            if (hs) begin
                case (phase)
                    0: begin ma = bus.in_data; mm = bus.in_mode; phase = 1; end
                    1: begin mb = bus.in_data; phase = 2; end
                    default: begin
                        infl.push_back(calc(ma, mb, bus.in_data, mm, edge_n + MS));
                        phase = 0;
                    end
                endcase
            end else if (abort_m) begin
                phase = 0;
            end
        end
    end

    // ---------------- drivers (called at posedge+1) ----------------
    task automatic send_word(input logic [W-1:0] d, input mode_t m);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_mode  = m;
        @(negedge clk);
        while (!bus.in_ready && t < 100) begin
            t++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_ready got 0 want 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] c, input mode_t m);
        send_word(a, m);
        send_word(b, m);
        send_word(c, m);
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_out(input string nm, input logic [W-1:0] d, input logic o);
        int t = 0;
        @(negedge clk);
        while (!bus.out_valid && t < 50) begin
            t++;
            @(negedge clk);
        end
        chk({nm, "_valid"}, bus.out_valid, 1);
        chk({nm, "_data"},  bus.out_data,  d);
        chk({nm, "_ovf"},   bus.out_ovf,   o);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = MODE_MAD;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // mode 00, 3*4+5, latency from the c handshake
        send_txn(3, 4, 5, MODE_MAD);
        @(negedge clk); chk("t1_lat0", bus.out_valid, 0);
        @(negedge clk); chk("t1_lat1", bus.out_valid, 0);
        @(negedge clk); chk("t1_lat2", bus.out_valid, 1);
        chk("t1_data", bus.out_data, 17);
        chk("t1_ovf",  bus.out_ovf,  0);
        @(posedge clk); #1;

        send_txn(2, 3, 10, MODE_MSB);
        expect_out("t2", 32'hFFFF_FFFC, 1'b1);
        send_txn(32'hFFFF_FFFF, 2, 9, MODE_MUL);
        expect_out("t3", 32'hFFFF_FFFE, 1'b1);

        // abort after a
        send_word(7, MODE_MAD);
        bus.in_valid = 1'b0;
        @(negedge clk); chk("t4_abort_pre",  bus.err_abort, 0);
        @(negedge clk); chk("t4_abort",      bus.err_abort, 1);
        @(negedge clk); chk("t4_abort_post", bus.err_abort, 0);
        @(posedge clk); #1;
        send_txn(1, 1, 1, MODE_MAD);
        expect_out("t4", 2, 1'b0);

        // backpressure: four results fill the credit
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send_txn(W'(i), W'(i), 0, MODE_MAD);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_credit_full", bus.in_ready, 0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        fork
            send_txn(5, 5, 0, MODE_MAD);
            begin
                for (int j = 1; j <= 5; j++) expect_out("t5", W'(j * j), 1'b0);
            end
        join

        // reset mid-transaction
        send_word(9, MODE_MAD);
        send_word(9, MODE_MAD);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t6_in_ready",  bus.in_ready,  1);
        chk("t6_out_valid", bus.out_valid, 0);
        chk("t6_err_abort", bus.err_abort, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); chk("t6_no_abort", bus.err_abort, 0);
        @(posedge clk); #1;
        send_txn(2, 2, 2, MODE_RSB);
        expect_out("t6", 32'hFFFF_FFFE, 1'b1);

        // randomized stream, one reset in the middle
        for (int c = 0; c < 1500; c++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 8);
            bus.in_data   = $urandom_range(0, 1) ? W'($urandom_range(0, 15)) : W'($urandom());
            bus.in_mode   = mode_t'($urandom_range(0, 3));
            bus.out_ready = ($urandom_range(0, 9) < 7);
            if (c == 700) rst = 1'b1;
            if (c == 702) rst = 1'b0;
            @(posedge clk);
            #1;
        end

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
